// File: rtl/byte_mem_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : byte_mem_burst_ctrl
// Brief   : Burst sequencer in front of a byte-banked memory with a busy handshake
// Revision: 1.0
// ============================================================================
module byte_mem_burst_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STRB_W     = 4,
   parameter int BURST_BITS = 2,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic                  req_wr,
   input  logic [STRB_W-1:0]     req_strb,
   input  logic [BURST_BITS-1:0] req_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_W-1:0]     wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_last,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_data_in,
   output logic [STRB_W-1:0]     mem_strb,
   output logic                  mem_wr,
   output logic [BURST_BITS-1:0] mem_burst_len,
   input  logic                  mem_busy,
   input  logic [DATA_W-1:0]     mem_data_out
);

   localparam int c_TW = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~ADDR_W'(STRB_W - 1);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_WBEAT = 3'd1;
   localparam logic [2:0] c_ISSUE = 3'd2;
   localparam logic [2:0] c_WAIT  = 3'd3;
   localparam logic [2:0] c_RDOUT = 3'd4;

   logic [2:0]            r_state;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W-1:0]     r_rdata;
   logic [STRB_W-1:0]     r_strb;
   logic                  r_wr;
   logic [BURST_BITS-1:0] r_len;
   logic [BURST_BITS-1:0] r_cnt;
   logic [c_TW-1:0]       r_tcnt;
   logic                  r_done;
   logic                  r_err;

   logic                  w_beat_done;
   logic                  w_abort;
   logic                  w_last;

   assign w_last = (r_cnt == r_len);

   // r_tcnt==0 in WAIT means busy has not been observed yet for this beat
   always_comb begin
      w_beat_done = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         c_WBEAT: w_beat_done = wr_valid && (r_strb == '0);
         c_WAIT: begin
            if (!mem_busy) begin
               if (r_tcnt == '0)
                  w_abort = 1'b1;
               else if (r_wr)
                  w_beat_done = 1'b1;
            end else if (r_tcnt == c_TW'(TIMEOUT)) begin
               w_abort = 1'b1;
            end
         end
         c_RDOUT: w_beat_done = rd_ready;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_strb  <= '0;
         r_wr    <= 1'b0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_tcnt  <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (r_state == c_WBEAT && wr_valid)
            r_wdata <= wr_data;
         if (w_abort) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= c_IDLE;
         end else if (w_beat_done) begin
            if (w_last) begin
               r_done  <= 1'b1;
               r_state <= c_IDLE;
            end else begin
               r_cnt   <= r_cnt + BURST_BITS'(1);
               r_addr  <= r_addr + ADDR_W'(STRB_W);
               r_state <= r_wr ? c_WBEAT : c_ISSUE;
            end
         end else begin
            case (r_state)
               c_IDLE: begin
                  if (req_valid) begin
                     r_addr  <= req_addr & c_ALIGN_MASK;
                     r_wr    <= req_wr;
                     r_strb  <= req_strb;
                     r_len   <= req_len;
                     r_cnt   <= '0;
                     r_state <= req_wr ? c_WBEAT : c_ISSUE;
                  end
               end
               c_WBEAT: begin
                  if (wr_valid)
                     r_state <= c_ISSUE;
               end
               c_ISSUE: begin
                  r_tcnt  <= '0;
                  r_state <= c_WAIT;
               end
               c_WAIT: begin
                  if (mem_busy) begin
                     r_tcnt <= r_tcnt + c_TW'(1);
                  end else begin
                     r_rdata <= mem_data_out;
                     r_state <= c_RDOUT;
                  end
               end
               c_RDOUT: ;
               default: r_state <= c_IDLE;
            endcase
         end
      end
   end

   assign req_ready     = (r_state == c_IDLE);
   assign wr_ready      = (r_state == c_WBEAT);
   assign rd_valid      = (r_state == c_RDOUT);
   assign rd_last       = (r_state == c_RDOUT) && w_last;
   assign rd_data       = r_rdata;
   assign done          = r_done;
   assign err           = r_err;
   assign mem_addr      = r_addr;
   assign mem_data_in   = r_wdata;
   assign mem_wr        = r_wr;
   assign mem_burst_len = r_len;
   assign mem_strb      = (r_state == c_ISSUE) ? (r_wr ? r_strb : '1) : '0;

endmodule
`default_nettype wire

// File: tb/tb_byte_mem_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_byte_mem_burst_ctrl
// Brief   : Directed bench for byte_mem_burst_ctrl with a behavioural busy memory
// Revision: 1.0
// ============================================================================
module tb_byte_mem_burst_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_wr;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [3:0]  req_strb;
   logic [1:0]  req_len;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic        rd_valid, rd_ready, rd_last;
   logic [31:0] rd_data;
   logic        done, err;
   logic [31:0] mem_addr, mem_data_in, mem_data_out;
   logic [3:0]  mem_strb;
   logic        mem_wr, mem_busy;
   logic [1:0]  mem_burst_len;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   byte_mem_burst_ctrl dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wr(req_wr), .req_strb(req_strb), .req_len(req_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .done(done), .err(err),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_strb(mem_strb),
      .mem_wr(mem_wr), .mem_burst_len(mem_burst_len),
      .mem_busy(mem_busy), .mem_data_out(mem_data_out)
   );

   // Memory model: busy rises the cycle after a request and stays high lat cycles
   logic [31:0] mem [0:255];
   logic        m_busy;
   logic [31:0] m_rdata;
   int          m_cnt;
   int          lat;
   bit          noresp;
   bit          pl_en;
   logic [7:0]  pl_idx;
   logic [31:0] pl_val;
   logic [31:0] q_addr[$];
   logic [31:0] q_data[$];
   logic [3:0]  q_strb[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy  <= 1'b0;
         m_cnt   <= 0;
         m_rdata <= '0;
      end else if (pl_en) begin
         mem[pl_idx] <= pl_val;
      end else if (mem_strb != 4'h0) begin
         if (!noresp) begin
            m_busy <= 1'b1;
            m_cnt  <= lat;
         end
         if (mem_wr) begin
            for (int b = 0; b < 4; b++)
               if (mem_strb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_data_in[8*b +: 8];
         end else begin
            m_rdata <= mem[mem_addr[9:2]];
         end
         q_addr.push_back(mem_addr);
         q_data.push_back(mem_data_in);
         q_strb.push_back(mem_strb);
      end else if (m_busy) begin
         if (m_cnt <= 1) m_busy <= 1'b0;
         m_cnt <= m_cnt - 1;
      end
   end

   assign mem_busy     = m_busy;
   assign mem_data_out = m_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] val);
      pl_en = 1'b1; pl_idx = idx; pl_val = val;
      step();
      pl_en = 1'b0;
   endtask

   task automatic send_cmd(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [1:0] l);
      int t = 0;
      req_valid = 1'b1; req_addr = a; req_wr = w; req_strb = s; req_len = l;
      while (!req_ready && t < 50) begin step(); t++; end
      step();
      req_valid = 1'b0;
   endtask

   task automatic wr_beat(input logic [31:0] d);
      int t = 0;
      wr_valid = 1'b1; wr_data = d;
      while (!wr_ready && t < 50) begin step(); t++; end
      if (!wr_ready) check("wr_ready_timeout", 32'(wr_ready), 32'd1);
      step();
      wr_valid = 1'b0;
   endtask

   task automatic rd_beat(input logic [31:0] exp, input logic exp_last, input int hold);
      int t = 0;
      int n_iss;
      bit ok = 1'b1;
      while (!rd_valid && t < 50) begin step(); t++; end
      check("rd_valid", 32'(rd_valid), 32'd1);
      check("rd_data", rd_data, exp);
      check("rd_last", 32'(rd_last), 32'(exp_last));
      if (hold > 0) begin
         n_iss = q_addr.size();
         for (int k = 0; k < hold; k++) begin
            step();
            if (!rd_valid || rd_data !== exp || mem_strb !== 4'h0) ok = 1'b0;
         end
         check("rd_hold_stable", 32'(ok), 32'd1);
         check("no_issue_in_hold", 32'(q_addr.size()), 32'(n_iss));
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
   endtask

   task automatic wait_done(input logic exp_err);
      int t = 0;
      while (!done && t < 100) begin step(); t++; end
      check("done", 32'(done), 32'd1);
      check("err", 32'(err), 32'(exp_err));
      step();
   endtask

   initial begin
      int  n;
      bit  seen;
      reset = 1'b1; req_valid = 0; req_addr = 0; req_wr = 0; req_strb = 0; req_len = 0;
      wr_valid = 0; wr_data = 0; rd_ready = 0; lat = 1; noresp = 0;
      pl_en = 0; pl_idx = 0; pl_val = 0;
      step(); step();
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_outs", {wr_ready, rd_valid, rd_last, done, err, mem_wr, mem_strb}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      reset = 1'b0;
      preload(8'd64,  32'hA5A5_1234);
      preload(8'd16,  32'h1122_3344);
      preload(8'd255, 32'hCAFE_F00D);
      preload(8'd0,   32'h0BAD_BEEF);

      // Single-beat read with exact latency
      n = q_addr.size();
      send_cmd(32'h0000_0100, 1'b0, 4'h0, 2'd0);
      check("t1_strb_issue", 32'(mem_strb), 32'hF);
      check("t1_addr", mem_addr, 32'h100);
      step();
      check("t1_strb_wait", 32'(mem_strb), 32'h0);
      step();
      check("t1_rdv_e2", 32'(rd_valid), 32'd0);
      step();
      check("t1_rdv_e3", 32'(rd_valid), 32'd1);
      rd_beat(32'hA5A5_1234, 1'b1, 0);
      wait_done(1'b0);
      check("t1_issues", 32'(q_addr.size() - n), 32'd1);

      // Four-beat write then readback
      n = q_addr.size();
      send_cmd(32'h0000_0020, 1'b1, 4'hF, 2'd3);
      check("t2_burst_len", 32'(mem_burst_len), 32'd3);
      for (int i = 0; i < 4; i++) wr_beat(32'(i + 1));
      wait_done(1'b0);
      check("t2_issues", 32'(q_addr.size() - n), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("t2_addr", q_addr[n+i], 32'h20 + 32'(4*i));
         check("t2_data", q_data[n+i], 32'(i + 1));
         check("t2_strb", 32'(q_strb[n+i]), 32'hF);
      end
      send_cmd(32'h0000_0020, 1'b0, 4'h0, 2'd3);
      for (int i = 0; i < 4; i++) rd_beat(32'(i + 1), (i == 3), 0);
      wait_done(1'b0);

      // Read back-pressure
      send_cmd(32'h0000_0020, 1'b0, 4'h0, 2'd1);
      rd_beat(32'd1, 1'b0, 5);
      rd_beat(32'd2, 1'b1, 5);
      wait_done(1'b0);

      // Zero strobe write skips memory, partial strobe writes banks 0/1 only
      n = q_addr.size();
      send_cmd(32'h0000_0040, 1'b1, 4'h0, 2'd1);
      wr_beat(32'h5555_5555);
      wr_beat(32'h6666_6666);
      wait_done(1'b0);
      check("t4_no_issue", 32'(q_addr.size()), 32'(n));
      send_cmd(32'h0000_0041, 1'b1, 4'h3, 2'd0);
      wr_beat(32'hDEAD_BEEF);
      wait_done(1'b0);
      check("t4_strb3", 32'(q_strb[n]), 32'h3);
      send_cmd(32'h0000_0040, 1'b0, 4'h0, 2'd0);
      rd_beat(32'h1122_BEEF, 1'b1, 0);
      wait_done(1'b0);

      // Busy high 16 cycles aborts, 15 cycles completes
      lat = 16;
      send_cmd(32'h0000_0100, 1'b0, 4'h0, 2'd0);
      repeat (16) step();
      check("t5_no_early_done", 32'(done), 32'd0);
      step();
      check("t5_timeout_done", 32'(done), 32'd1);
      check("t5_timeout_err", 32'(err), 32'd1);
      step();
      lat = 15;
      send_cmd(32'h0000_0100, 1'b0, 4'h0, 2'd0);
      rd_beat(32'hA5A5_1234, 1'b1, 0);
      wait_done(1'b0);
      lat = 1;
      noresp = 1'b1;
      send_cmd(32'h0000_0100, 1'b0, 4'h0, 2'd0);
      step(); step();
      check("t5_noresp_done", 32'(done), 32'd1);
      check("t5_noresp_err", 32'(err), 32'd1);
      noresp = 1'b0;
      step();

      // Asynchronous reset during WAIT of beat 2
      send_cmd(32'h0000_0020, 1'b0, 4'h0, 2'd3);
      rd_beat(32'd1, 1'b0, 0);
      step();
      reset = 1'b1;
      #1;
      check("t6_req_ready", 32'(req_ready), 32'd1);
      check("t6_outs", {wr_ready, rd_valid, rd_last, done, err, mem_wr, mem_strb}, 32'd0);
      check("t6_addr", mem_addr, 32'd0);
      check("t6_len", 32'(mem_burst_len), 32'd0);
      step();
      reset = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin step(); if (done) seen = 1'b1; end
      check("t6_no_done", 32'(seen), 32'd0);

      // Address wraps past the top of the space
      n = q_addr.size();
      send_cmd(32'hFFFF_FFFC, 1'b0, 4'h0, 2'd1);
      rd_beat(32'hCAFE_F00D, 1'b0, 0);
      rd_beat(32'h0BAD_BEEF, 1'b1, 0);
      wait_done(1'b0);
      check("t7_addr0", q_addr[n], 32'hFFFF_FFFC);
      check("t7_addr1", q_addr[n+1], 32'h0000_0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
